// File: rtl/intlv_word_packer.sv
// intlv_word_packer
// Serial-to-parallel packer in front of the Tx interleaver. Coded bits are
// gathered into 18-bit words of K = 3/6/12/18 bits (BPSK/QPSK/16QAM/64QAM),
// 16 words per OFDM symbol, and handed to the bit-order regulator over a
// valid/ready handshake.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   sym_start   in   1-cycle start-of-symbol pulse, latches mod when IDLE
//   mod         in   [1:0] 0=BPSK 1=QPSK 2=16QAM 3=64QAM
//   bit_in      in   coded bit
//   bit_valid   in   bit_in valid
//   bit_ready   out  packer accepts bit_in this cycle
//   word_out    out  [17:0] packed word, bit i = i-th bit received, bits >= K zero
//   word_mod    out  [1:0] modulation of word_out
//   word_valid  out  word_out valid
//   word_ready  in   downstream accepts word_out
//   word_last   out  word_out is the last word of the symbol
//   err         out  sticky: sym_start seen while a symbol was in progress
module intlv_word_packer #(
    parameter int unsigned WORDS_PER_SYM = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sym_start,
    input  logic [1:0]  mod,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic [17:0] word_out,
    output logic [1:0]  word_mod,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic        err
);

    localparam int unsigned WcW = $clog2(WORDS_PER_SYM);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e          state_q, state_d;
    logic [1:0]      mod_q, mod_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [WcW-1:0]  word_cnt_q, word_cnt_d;
    logic [17:0]     fill_q, fill_d;
    logic            fill_full_q, fill_full_d;
    logic [17:0]     word_out_q, word_out_d;
    logic [1:0]      word_mod_q, word_mod_d;
    logic            word_valid_q, word_valid_d;
    logic            word_last_q, word_last_d;
    logic            err_q, err_d;

    logic [4:0]      k_m1;
    logic            slot_free;
    logic            accept;
    logic            word_done;
    logic            xfer;
    logic [17:0]     fill_bits;

    always_comb begin
        unique case (mod_q)
            2'd0:    k_m1 = 5'd2;
            2'd1:    k_m1 = 5'd5;
            2'd2:    k_m1 = 5'd11;
            default: k_m1 = 5'd17;
        endcase
    end

    assign bit_ready = (state_q == StFill) && !fill_full_q;
    assign slot_free = !word_valid_q || word_ready;
    assign accept    = bit_valid && bit_ready;
    assign word_done = accept && (bit_cnt_q == k_m1);
    // A completed word moves out either straight from the incoming bit or,
    // after a stall, from the held full fill register.
    assign xfer      = (word_done || fill_full_q) && slot_free;

    // Fill contents including the bit being accepted this cycle, so a word
    // can be loaded on the same edge its last bit arrives.
    always_comb begin
        fill_bits = fill_q;
        if (accept) begin
            fill_bits[bit_cnt_q] = bit_in;
        end
    end

    always_comb begin
        state_d      = state_q;
        mod_d        = mod_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        fill_d       = fill_q;
        fill_full_d  = fill_full_q;
        word_out_d   = word_out_q;
        word_mod_d   = word_mod_q;
        word_valid_d = word_valid_q;
        word_last_d  = word_last_q;
        err_d        = err_q;

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // The output register may still hold the previous symbol's
                // last word; it is left untouched here.
                if (sym_start) begin
                    mod_d      = mod;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (sym_start) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    fill_d    = fill_bits;
                    bit_cnt_d = word_done ? 5'd0 : bit_cnt_q + 5'd1;
                    if (word_done && !slot_free) begin
                        fill_full_d = 1'b1;
                    end
                end
                if (xfer) begin
                    word_out_d   = fill_bits;
                    word_mod_d   = mod_q;
                    word_last_d  = (word_cnt_q == WcW'(WORDS_PER_SYM - 1));
                    word_valid_d = 1'b1;
                    fill_d       = '0;
                    fill_full_d  = 1'b0;
                    if (word_cnt_q == WcW'(WORDS_PER_SYM - 1)) begin
                        word_cnt_d = '0;
                        state_d    = StIdle;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mod_q        <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            fill_q       <= '0;
            fill_full_q  <= 1'b0;
            word_out_q   <= '0;
            word_mod_q   <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mod_q        <= mod_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            fill_q       <= fill_d;
            fill_full_q  <= fill_full_d;
            word_out_q   <= word_out_d;
            word_mod_q   <= word_mod_d;
            word_valid_q <= word_valid_d;
            word_last_q  <= word_last_d;
            err_q        <= err_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_mod   = word_mod_q;
    assign word_valid = word_valid_q;
    assign word_last  = word_last_q;
    assign err        = err_q;

endmodule

// File: tb/tb_intlv_word_packer.sv
// Directed bench for intlv_word_packer: BPSK/64QAM streaming, QPSK
// backpressure, 16QAM with a stray sym_start, async reset mid-word and
// symbol chaining while the last word is still held.
module tb_intlv_word_packer;

    logic        clk;
    logic        rst_n;
    logic        sym_start;
    logic [1:0]  mod;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [17:0] word_out;
    logic [1:0]  word_mod;
    logic        word_valid;
    logic        word_ready;
    logic        word_last;
    logic        err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    intlv_word_packer #(.WORDS_PER_SYM(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_start  (sym_start),
        .mod        (mod),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .word_out   (word_out),
        .word_mod   (word_mod),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // QPSK word values, 6 bits each
    function automatic logic [5:0] qval(int w);
        return 6'((w * 11 + 5) & 63);
    endfunction

    function automatic logic qbit(int b);
        logic [5:0] v;
        v = qval(b / 6);
        return v[b % 6];
    endfunction

    // 16QAM word values, 12 bits each
    function automatic logic [11:0] hval(int w);
        return 12'((w * 291 + 17) & 4095);
    endfunction

    function automatic logic hbit(int b);
        logic [11:0] v;
        v = hval(b / 12);
        return v[b % 12];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sym_start  = 1'b0;
        mod        = 2'd0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        rst_n      = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_sym(input logic [1:0] m);
        mod       = m;
        sym_start = 1'b1;
        step();
        sym_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if (word_out !== 18'h0) $display("FAIL rst_word_out: got %h exp 0", word_out); else pass_cnt++;
        chk_cnt++; if (word_mod !== 2'd0) $display("FAIL rst_word_mod: got %0d exp 0", word_mod); else pass_cnt++;
        chk_cnt++; if (word_valid !== 1'b0) $display("FAIL rst_word_valid: got %b exp 0", word_valid); else pass_cnt++;
        chk_cnt++; if (word_last !== 1'b0) $display("FAIL rst_word_last: got %b exp 0", word_last); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b exp 0", err); else pass_cnt++;
        // Bits offered while IDLE must be ignored
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (bit_ready !== 1'b0) $display("FAIL idle_bit_ready: got %b exp 0", bit_ready); else pass_cnt++;
            step();
        end
        bit_valid = 1'b0;
        chk_cnt++; if (word_valid !== 1'b0) $display("FAIL idle_no_word: got %b exp 0", word_valid); else pass_cnt++;
    endtask

    task automatic test_bpsk();
        int nw = 0;
        word_ready = 1'b1;
        start_sym(2'd0);
        for (int i = 0; i < 48; i++) begin
            bit_valid = 1'b1;
            bit_in    = (i % 3 == 0);
            step();
            chk_cnt++; if (word_valid !== (i % 3 == 2)) $display("FAIL bpsk_valid bit %0d: got %b exp %b", i, word_valid, (i % 3 == 2)); else pass_cnt++;
            if (word_valid) begin
                nw++;
                chk_cnt++; if (word_out !== 18'h00001) $display("FAIL bpsk_word %0d: got %h exp 00001", nw, word_out); else pass_cnt++;
                chk_cnt++; if (word_last !== (nw == 16)) $display("FAIL bpsk_last %0d: got %b exp %b", nw, word_last, (nw == 16)); else pass_cnt++;
                chk_cnt++; if (word_mod !== 2'd0) $display("FAIL bpsk_mod: got %0d exp 0", word_mod); else pass_cnt++;
            end
        end
        bit_valid = 1'b0;
        chk_cnt++; if (nw != 16) $display("FAIL bpsk_count: got %0d exp 16", nw); else pass_cnt++;
        chk_cnt++; if (bit_ready !== 1'b0) $display("FAIL bpsk_idle_after: got %b exp 0", bit_ready); else pass_cnt++;
        step();
        chk_cnt++; if (word_valid !== 1'b0) $display("FAIL bpsk_valid_drop: got %b exp 0", word_valid); else pass_cnt++;
    endtask

    task automatic test_64qam();
        int nw = 0;
        word_ready = 1'b1;
        start_sym(2'd3);
        for (int i = 0; i < 288; i++) begin
            chk_cnt++; if (bit_ready !== 1'b1) $display("FAIL qam64_bit_ready bit %0d: got %b exp 1", i, bit_ready); else pass_cnt++;
            bit_valid = 1'b1;
            bit_in    = i[0];
            step();
            chk_cnt++; if (word_valid !== (i % 18 == 17)) $display("FAIL qam64_valid bit %0d: got %b exp %b", i, word_valid, (i % 18 == 17)); else pass_cnt++;
            if (word_valid) begin
                nw++;
                chk_cnt++; if (word_out !== 18'h2AAAA) $display("FAIL qam64_word %0d: got %h exp 2aaaa", nw, word_out); else pass_cnt++;
                chk_cnt++; if (word_mod !== 2'd3) $display("FAIL qam64_mod: got %0d exp 3", word_mod); else pass_cnt++;
                chk_cnt++; if (word_last !== (nw == 16)) $display("FAIL qam64_last %0d: got %b exp %b", nw, word_last, (nw == 16)); else pass_cnt++;
            end
        end
        bit_valid = 1'b0;
        chk_cnt++; if (nw != 16) $display("FAIL qam64_count: got %0d exp 16", nw); else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure();
        int b  = 0;
        int nw = 2;
        word_ready = 1'b0;
        start_sym(2'd1);
        for (int c = 0; c < 20; c++) begin
            if (bit_ready) begin
                bit_valid = 1'b1;
                bit_in    = qbit(b);
                b++;
            end else begin
                bit_valid = 1'b0;
            end
            step();
            if (c >= 5) begin
                chk_cnt++; if (word_out !== 18'(qval(0)) || word_valid !== 1'b1) $display("FAIL bp_hold cyc %0d: got %h/%b exp %h/1", c, word_out, word_valid, qval(0)); else pass_cnt++;
            end
        end
        bit_valid = 1'b0;
        chk_cnt++; if (bit_ready !== 1'b0) $display("FAIL bp_stall_ready: got %b exp 0", bit_ready); else pass_cnt++;
        chk_cnt++; if (b != 12) $display("FAIL bp_bits_taken: got %0d exp 12", b); else pass_cnt++;
        word_ready = 1'b1;
        step();
        chk_cnt++; if (word_out !== 18'(qval(1))) $display("FAIL bp_word2: got %h exp %h", word_out, qval(1)); else pass_cnt++;
        chk_cnt++; if (word_valid !== 1'b1) $display("FAIL bp_word2_valid: got %b exp 1", word_valid); else pass_cnt++;
        chk_cnt++; if (bit_ready !== 1'b1) $display("FAIL bp_resume_ready: got %b exp 1", bit_ready); else pass_cnt++;
        for (int c = 0; c < 200 && nw < 16; c++) begin
            if (bit_ready && b < 96) begin
                bit_valid = 1'b1;
                bit_in    = qbit(b);
                b++;
            end else begin
                bit_valid = 1'b0;
            end
            step();
            if (word_valid) begin
                chk_cnt++; if (word_out !== 18'(qval(nw))) $display("FAIL bp_word %0d: got %h exp %h", nw, word_out, qval(nw)); else pass_cnt++;
                chk_cnt++; if (word_last !== (nw == 15)) $display("FAIL bp_last %0d: got %b exp %b", nw, word_last, (nw == 15)); else pass_cnt++;
                nw++;
            end
        end
        bit_valid = 1'b0;
        chk_cnt++; if (nw != 16) $display("FAIL bp_count: got %0d exp 16", nw); else pass_cnt++;
        step();
    endtask

    task automatic test_sym_err();
        int nw = 0;
        word_ready = 1'b1;
        start_sym(2'd2);
        for (int i = 0; i < 192; i++) begin
            bit_valid = 1'b1;
            bit_in    = hbit(i);
            sym_start = (i == 5);
            mod       = (i == 5) ? 2'd0 : 2'd2;
            step();
            chk_cnt++; if (word_valid !== (i % 12 == 11)) $display("FAIL err_valid bit %0d: got %b exp %b", i, word_valid, (i % 12 == 11)); else pass_cnt++;
            if (word_valid) begin
                chk_cnt++; if (word_out !== 18'(hval(nw))) $display("FAIL err_word %0d: got %h exp %h", nw, word_out, hval(nw)); else pass_cnt++;
                chk_cnt++; if (word_mod !== 2'd2) $display("FAIL err_mod %0d: got %0d exp 2", nw, word_mod); else pass_cnt++;
                nw++;
            end
        end
        sym_start = 1'b0;
        bit_valid = 1'b0;
        chk_cnt++; if (err !== 1'b1) $display("FAIL err_flag: got %b exp 1", err); else pass_cnt++;
        chk_cnt++; if (nw != 16) $display("FAIL err_count: got %0d exp 16", nw); else pass_cnt++;
        step();
        chk_cnt++; if (err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", err); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        word_ready = 1'b1;
        start_sym(2'd1);
        for (int i = 0; i < 39; i++) begin
            bit_valid  = 1'b1;
            bit_in     = qbit(i);
            word_ready = (i < 36);
            step();
        end
        chk_cnt++; if (word_valid !== 1'b1 || word_out !== 18'(qval(5))) $display("FAIL rstmid_pre: got %b/%h exp 1/%h", word_valid, word_out, qval(5)); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (word_valid !== 1'b0) $display("FAIL rstmid_valid: got %b exp 0", word_valid); else pass_cnt++;
        chk_cnt++; if (word_out !== 18'h0) $display("FAIL rstmid_word: got %h exp 0", word_out); else pass_cnt++;
        chk_cnt++; if (word_mod !== 2'd0 || word_last !== 1'b0 || err !== 1'b0) $display("FAIL rstmid_misc: got %0d/%b/%b exp 0/0/0", word_mod, word_last, err); else pass_cnt++;
        chk_cnt++; if (bit_ready !== 1'b0) $display("FAIL rstmid_ready: got %b exp 0", bit_ready); else pass_cnt++;
        bit_valid = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        word_ready = 1'b1;
        step();
        start_sym(2'd0);
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            bit_in    = (i < 2);
            step();
        end
        bit_valid = 1'b0;
        chk_cnt++; if (word_valid !== 1'b1 || word_out !== 18'h00003) $display("FAIL rstmid_new_word: got %b/%h exp 1/00003", word_valid, word_out); else pass_cnt++;
        chk_cnt++; if (word_mod !== 2'd0) $display("FAIL rstmid_new_mod: got %0d exp 0", word_mod); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_chaining();
        word_ready = 1'b1;
        start_sym(2'd0);
        for (int i = 0; i < 48; i++) begin
            bit_valid  = 1'b1;
            bit_in     = (i == 45 || i == 47);
            word_ready = (i < 47);
            step();
        end
        bit_valid = 1'b0;
        chk_cnt++; if (word_valid !== 1'b1 || word_out !== 18'h00005) $display("FAIL chain_w16: got %b/%h exp 1/00005", word_valid, word_out); else pass_cnt++;
        chk_cnt++; if (word_last !== 1'b1) $display("FAIL chain_w16_last: got %b exp 1", word_last); else pass_cnt++;
        chk_cnt++; if (bit_ready !== 1'b0) $display("FAIL chain_idle: got %b exp 0", bit_ready); else pass_cnt++;
        start_sym(2'd1);
        chk_cnt++; if (err !== 1'b0) $display("FAIL chain_err: got %b exp 0", err); else pass_cnt++;
        chk_cnt++; if (bit_ready !== 1'b1) $display("FAIL chain_accept: got %b exp 1", bit_ready); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1;
            bit_in    = i[0];
            step();
            chk_cnt++; if (word_out !== 18'h00005 || word_valid !== 1'b1 || word_last !== 1'b1 || word_mod !== 2'd0) $display("FAIL chain_hold %0d: got %h/%b/%b/%0d exp 00005/1/1/0", i, word_out, word_valid, word_last, word_mod); else pass_cnt++;
        end
        bit_valid = 1'b0;
        chk_cnt++; if (bit_ready !== 1'b0) $display("FAIL chain_full: got %b exp 0", bit_ready); else pass_cnt++;
        word_ready = 1'b1;
        step();
        chk_cnt++; if (word_out !== 18'h0002A || word_valid !== 1'b1) $display("FAIL chain_new_word: got %h/%b exp 0002a/1", word_out, word_valid); else pass_cnt++;
        chk_cnt++; if (word_mod !== 2'd1 || word_last !== 1'b0) $display("FAIL chain_new_meta: got %0d/%b exp 1/0", word_mod, word_last); else pass_cnt++;
        chk_cnt++; if (bit_ready !== 1'b1) $display("FAIL chain_new_ready: got %b exp 1", bit_ready); else pass_cnt++;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_bpsk();
        test_64qam();
        test_backpressure();
        test_sym_err();
        test_reset_mid();
        test_chaining();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
